karatsuba32_arb: RTL
====================

# karatsuba32_arb

Two-requester arbiter and sequencer around a single shared `karatsuba32` combinational multiplier (ports `P`, `A`, `B`; 32x32 -> 64, unsigned). The block latches the granted requester's operands into registers driving the multiplier. It waits a fixed number of settle cycles for the deep combinational tree, then captures `P` into a result register and returns it with a valid/ready handshake. It sits between the datapath clients and the multiplier so one multiplier instance can serve both clients.

## Interface
- `SETTLE_CYCLES`, default 2: cycles between operand latch and product capture; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset (sampled on `clk` rising edge).
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  per-requester request accept; at most one bit set.
- `req_a0`, `req_b0`  in  32 each  requester 0 operands.
- `req_a1`, `req_b1`  in  32 each  requester 1 operands.
- `res_valid`  out  2  per-requester result valid; at most one bit set.
- `res_ready`  in  2  per-requester result accept.
- `res_p`  out  64  product for the requester whose `res_valid` bit is set.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Reset: state=IDLE; `res_valid`=0, `res_p`=0, `busy`=0; operand registers=0; `last_grant`=1, so requester 0 has first priority.
- IDLE:
  - Grant selection is combinational from `req_valid` and `last_grant`.
  - `req_ready[g]`=1 only for the selected requester g and only in IDLE; `req_ready` depends on `req_valid`.
  - On the edge where `req_valid[g] && req_ready[g]`: latch that requester's A/B into the operand registers, record g, set `last_grant`=g, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - The operand registers drive `karatsuba32` `A`/`B`.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: capture `P` into `res_p`, set `res_valid[g]`=1, go to RESP.
  - Requests are ignored in this state; `req_ready`=0.
- RESP:
  - `res_valid[g]` and `res_p` are held stable until `res_ready[g]`=1.
  - On the edge where the handshake completes: clear `res_valid`, go to IDLE. `res_p` retains its value.
  - `res_ready` bits for the non-granted requester are ignored.
- Arithmetic: full 64-bit unsigned product, no truncation, no rounding. The operand registers are 32 bits each.
- Requester may drop `req_valid` before acceptance; no transaction is recorded.
- Reset asserted in any state aborts the operation and discards the result. All outputs return to reset values on that edge.

## Timing
- Accept edge = T. `res_valid` rises after edge T+SETTLE_CYCLES and is visible in the cycle following it.
- Minimum occupancy per operation = SETTLE_CYCLES+2 cycles:
  - 1 cycle for accept,
  - SETTLE_CYCLES cycles settling,
  - ≥1 cycle in RESP.
- The state returns to IDLE on the response-handshake edge. The next request is accepted no earlier than the following edge; there is no same-edge overlap.
- `busy` is registered. It is 1 from edge T through the response-handshake edge.

## Configuration
- `KARA_ARB_RR_EN` defined: round-robin arbitration. When both requesters are valid in IDLE, the requester not equal to `last_grant` wins. When only one is valid, it wins.
- `KARA_ARB_RR_EN` undefined: fixed priority. Requester 0 always wins when valid. `last_grant` is still recorded but does not affect selection.

## Test plan
- Single op, requester 0: A=65536, B=100, SETTLE_CYCLES=2. Required: `res_valid[0]` visible 2 cycles after the accept edge, `res_p`=6553600, `busy` high throughout.
- Max operands, requester 1: A=B=4294967295. Required: `res_p`=18446744065119617025 (0xFFFFFFFE00000001), `res_valid[1]` only.
- Both requesters valid continuously, r0 A=58 B=84607, r1 A=73066 B=615406.
  - With `KARA_ARB_RR_EN`: grants alternate 0,1,0,1, results alternate 4907206 / 44965254796.
  - Without it: requester 0 is granted every time.
- Backpressure: `res_ready[0]` held low 5 cycles after `res_valid[0]`. Required: `res_p` stable, `req_ready`=0 throughout, new requests are not accepted until one cycle after the handshake.
- Reset mid-SETTLE: `rst_n`=0 for 1 cycle. Required: all outputs at reset values next cycle, no `res_valid` for the aborted op, the next request is served with the correct product.
- Zero operand: A=0, B=4294967295. Required: `res_p`=0.

Source files
------------

// File: rtl/karatsuba32_arb.sv
// karatsuba32_arb: two-requester arbiter sequencing one shared combinational karatsuba32 multiplier.
// Define KARA_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module karatsuba32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] P
);
    logic [15:0] al, ah, bl, bh;
    logic [31:0] z0, z2;
    logic [16:0] sa, sb;
    logic [33:0] z1f, z1;
    always_comb begin
        {ah, al} = A;
        {bh, bl} = B;
        z0 = 32'(al) * 32'(bl);
        z2 = 32'(ah) * 32'(bh);
        sa = 17'(ah) + 17'(al);
        sb = 17'(bh) + 17'(bl);
        z1f = 34'(sa) * 34'(sb);
        // cross term is never negative, so 34 bits hold it without wrap
        z1 = z1f - 34'(z2) - 34'(z0);
        P = {z2, z0} + {14'b0, z1, 16'b0};
    end
endmodule

module karatsuba32_arb #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [1:0]  res_valid,
    input  logic [1:0]  res_ready,
    output logic [63:0] res_p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        g_q, g_d, last_q, last_d, busy_q, sel;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] p_q, p_d, prod;
    logic [1:0]  rv_q, rv_d;

    karatsuba32 u_mul (.A(a_q), .B(b_q), .P(prod));

    always_comb begin
`ifdef KARA_ARB_RR_EN
        sel = (&req_valid) ? ~last_q : ~req_valid[0];
`else
        sel = ~req_valid[0];
`endif
        req_ready = (state_q == IDLE) ? (req_valid & (sel ? 2'b10 : 2'b01)) : 2'b00;
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        g_d = g_q;
        last_d = last_q;
        cnt_d = cnt_q;
        p_d = p_q;
        rv_d = rv_q;
        case (state_q)
            IDLE: if (|req_ready) begin
                a_d = sel ? req_a1 : req_a0;
                b_d = sel ? req_b1 : req_b0;
                g_d = sel;
                last_d = sel;
                cnt_d = 4'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: if (cnt_q == 4'd0) begin
                p_d = prod;
                rv_d = g_q ? 2'b10 : 2'b01;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: if (|(rv_q & res_ready)) begin
                rv_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            g_q <= 1'b0;
            last_q <= 1'b1;
            cnt_q <= '0;
            p_q <= '0;
            rv_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            g_q <= g_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            p_q <= p_d;
            rv_q <= rv_d;
            busy_q <= (state_d != IDLE);
        end
    end

    assign res_valid = rv_q;
    assign res_p = p_q;
    assign busy = busy_q;
endmodule
